// File: rtl/blend_pkg.sv
// Shared types and constants for the per-scanline blend scheduler.
package blend_pkg;

  localparam int          H_PIXELS_DEFAULT = 240;
  localparam logic [15:0] WHITE_COLOR      = 16'h7FFF;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} sched_state_t;

  typedef struct packed {
    logic [19:0] layer0;
    logic [19:0] layer1;
    logic [14:0] color0;
    logic [14:0] color1;
    logic [4:0]  effects;
  } blend_operands_t;

endpackage

// File: rtl/blend_shadow_regs.sv
// Line-stable copies of BLDCNT/BLDALPHA/BLDY and the scanline number,
// captured only when the scheduler starts a new line.
module blend_shadow_regs (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] bldcnt_io,
  input  logic [15:0] bldalpha_io,
  input  logic [15:0] bldy_io,
  input  logic [7:0]  vcount,
  output logic [15:0] bldcnt,
  output logic [15:0] bldalpha,
  output logic [15:0] bldy,
  output logic [7:0]  line_y
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bldcnt   <= '0;
      bldalpha <= '0;
      bldy     <= '0;
      line_y   <= '0;
    end else if (load) begin
      bldcnt   <= bldcnt_io;
      bldalpha <= bldalpha_io;
      bldy     <= bldy_io;
      line_y   <= vcount;
    end
  end

endmodule

// File: rtl/blend_line_sched.sv
// Scanline scheduler: latches blend shadow regs at line start and streams
// H_PIXELS operand sets through a 2-stage valid/ready pipeline.
// Optional: BLEND_FORCE_BLANK_EN adds a per-pixel force_blank input.
module blend_line_sched
  import blend_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEFAULT,
  parameter int X_W      = 8
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           line_start,
  input  logic [7:0]     vcount,
  input  logic [15:0]    bldcnt_io,
  input  logic [15:0]    bldalpha_io,
  input  logic [15:0]    bldy_io,
  input  logic           px_valid,
  output logic           px_ready,
  input  logic [19:0]    px_layer0,
  input  logic [19:0]    px_layer1,
  input  logic [14:0]    px_color0,
  input  logic [14:0]    px_color1,
  input  logic [4:0]     px_effects,
`ifdef BLEND_FORCE_BLANK_EN
  input  logic           force_blank,
`endif
  output logic [19:0]    blend_layer0,
  output logic [19:0]    blend_layer1,
  output logic [14:0]    blend_color0,
  output logic [14:0]    blend_color1,
  output logic [4:0]     blend_effects,
  output logic [15:0]    blend_bldcnt,
  output logic [15:0]    blend_bldalpha,
  output logic [15:0]    blend_bldy,
  input  logic [15:0]    blend_color,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [15:0]    out_color,
  output logic [X_W-1:0] out_x,
  output logic [7:0]     out_y,
  output logic           line_done,
  output logic           overrun
);

  localparam logic [X_W-1:0] LAST_X = X_W'(H_PIXELS - 1);

  sched_state_t    state, state_nxt;
  logic [2:1]      vld_pipe;
  logic            adv1, adv2, px_fire, out_fire, last_in, shadow_load;
  logic [X_W-1:0]  in_x, s1_x;
  blend_operands_t s1_ops;
  logic [15:0]     s2_color_nxt;
  logic [7:0]      line_y;

  assign adv2        = !vld_pipe[2] | out_ready;
  assign adv1        = !vld_pipe[1] | adv2;
  assign px_ready    = (state == RUN) & adv1;
  assign px_fire     = px_valid & px_ready;
  assign out_fire    = vld_pipe[2] & out_ready;
  assign last_in     = (in_x == LAST_X);
  assign shadow_load = line_start & (state == IDLE);
  assign overrun     = line_start & (state != IDLE);
  // The last pixel leaving s2 implies s1 is already empty.
  assign line_done   = out_fire & (out_x == LAST_X);
  assign out_valid   = vld_pipe[2];

  blend_shadow_regs u_shadow (
    .clock       (clock),
    .reset_n     (reset_n),
    .load        (shadow_load),
    .bldcnt_io   (bldcnt_io),
    .bldalpha_io (bldalpha_io),
    .bldy_io     (bldy_io),
    .vcount      (vcount),
    .bldcnt      (blend_bldcnt),
    .bldalpha    (blend_bldalpha),
    .bldy        (blend_bldy),
    .line_y      (line_y)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (line_start) state_nxt = RUN;
      RUN:     if (px_fire && last_in) state_nxt = DRAIN;
      DRAIN:   if (line_done || vld_pipe == 2'b00) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef BLEND_FORCE_BLANK_EN
  logic s1_fb;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     s1_fb <= 1'b0;
    else if (px_fire) s1_fb <= force_blank;
  end

  assign s2_color_nxt = s1_fb ? WHITE_COLOR : blend_color;
`else
  assign s2_color_nxt = blend_color;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_x      <= '0;
      s1_x      <= '0;
      s1_ops    <= '0;
      vld_pipe  <= '0;
      out_color <= '0;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      if (shadow_load)             in_x <= '0;
      else if (px_fire && !last_in) in_x <= in_x + 1'b1;

      if (adv1) vld_pipe[1] <= px_fire;
      if (px_fire) begin
        s1_ops <= '{layer0: px_layer0, layer1: px_layer1, color0: px_color0,
                    color1: px_color1, effects: px_effects};
        s1_x   <= in_x;
      end

      if (adv2) vld_pipe[2] <= vld_pipe[1];
      if (adv2 && vld_pipe[1]) begin
        out_color <= s2_color_nxt;
        out_x     <= s1_x;
        out_y     <= line_y;
      end else if (shadow_load) begin
        out_x <= '0;
      end
    end
  end

  assign blend_layer0  = s1_ops.layer0;
  assign blend_layer1  = s1_ops.layer1;
  assign blend_color0  = s1_ops.color0;
  assign blend_color1  = s1_ops.color1;
  assign blend_effects = s1_ops.effects;

endmodule

// File: tb/tb_blend_line_sched.sv
// Directed bench for blend_line_sched: full lines, shadow stability,
// backpressure, overrun, mid-line reset and (if enabled) force-blank.
module tb_blend_line_sched;

  logic        clock, reset_n, line_start;
  logic [7:0]  vcount;
  logic [15:0] bldcnt_io, bldalpha_io, bldy_io;
  logic        px_valid, px_ready;
  logic [19:0] px_layer0, px_layer1;
  logic [14:0] px_color0, px_color1;
  logic [4:0]  px_effects;
`ifdef BLEND_FORCE_BLANK_EN
  logic        force_blank;
`endif
  logic [19:0] blend_layer0, blend_layer1;
  logic [14:0] blend_color0, blend_color1;
  logic [4:0]  blend_effects;
  logic [15:0] blend_bldcnt, blend_bldalpha, blend_bldy, blend_color;
  logic        out_valid, out_ready;
  logic [15:0] out_color;
  logic [7:0]  out_x, out_y;
  logic        line_done, overrun;

  blend_line_sched #(.H_PIXELS(240), .X_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .line_start(line_start), .vcount(vcount),
    .bldcnt_io(bldcnt_io), .bldalpha_io(bldalpha_io), .bldy_io(bldy_io),
    .px_valid(px_valid), .px_ready(px_ready),
    .px_layer0(px_layer0), .px_layer1(px_layer1),
    .px_color0(px_color0), .px_color1(px_color1), .px_effects(px_effects),
`ifdef BLEND_FORCE_BLANK_EN
    .force_blank(force_blank),
`endif
    .blend_layer0(blend_layer0), .blend_layer1(blend_layer1),
    .blend_color0(blend_color0), .blend_color1(blend_color1),
    .blend_effects(blend_effects), .blend_bldcnt(blend_bldcnt),
    .blend_bldalpha(blend_bldalpha), .blend_bldy(blend_bldy),
    .blend_color(blend_color), .out_valid(out_valid), .out_ready(out_ready),
    .out_color(out_color), .out_x(out_x), .out_y(out_y),
    .line_done(line_done), .overrun(overrun)
  );

  // Stand-in blend datapath: a simple combinational mix of the two colours.
  assign blend_color = {1'b0, blend_color0 ^ blend_color1};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  int acc_cnt = 0, out_cnt = 0, done_cnt = 0, ovr_cnt = 0;
  int acc_base = 0, out_base = 0, done_base = 0, ovr_base = 0;
  int first_acc_cyc = 0, first_out_cyc = 0, first_stall = -1, first_drop = -1;
  logic [6:0] line_tag = '0;
  logic [7:0] line_y = '0;
  bit mon_en = 0, toggle = 0, fb_on = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] exp_col(input logic [6:0] tag, input int i, input bit fb);
    logic [14:0] c0;
    c0 = {tag, i[7:0]};
    return fb ? 16'h7FFF : {1'b0, c0 ^ 15'h5555};
  endfunction

  // Observes the handshakes that will complete at the coming rising edge.
  task automatic sample();
    int idx;
    if (px_valid && px_ready) begin
      if (acc_cnt == acc_base) first_acc_cyc = cyc;
      acc_cnt++;
    end
    if (out_valid && out_ready) begin
      idx = out_cnt - out_base;
      chk("out_x", 32'(out_x), idx);
      chk("out_color", 32'(out_color), 32'(exp_col(line_tag, idx, fb_on && idx == 5)));
      chk("out_y", 32'(out_y), 32'(line_y));
      if (out_cnt == out_base) first_out_cyc = cyc;
      out_cnt++;
    end
    if (line_done) begin
      done_cnt++;
      chk("line_done_x", (out_valid && out_ready) ? 32'(out_x) : 32'hFFFF, 239);
    end
    if (overrun) ovr_cnt++;
    if (toggle && first_stall < 0 && out_valid && !out_ready) first_stall = cyc;
    if (first_stall >= 0 && first_drop < 0 && !px_ready) first_drop = cyc;
  endtask

  task automatic tick();
    int ai;
    @(negedge clock);
    if (mon_en) sample();
    @(posedge clock);
    cyc++;
    #1;
    ai = acc_cnt - acc_base;
    px_color0 = {line_tag, ai[7:0]};
    if (toggle) out_ready = ~out_ready;
`ifdef BLEND_FORCE_BLANK_EN
    force_blank = fb_on && (ai == 5);
`endif
  endtask

  task automatic start_line(input logic [6:0] tag, input logic [7:0] y);
    line_tag  = tag;
    line_y    = y;
    acc_base  = acc_cnt;
    out_base  = out_cnt;
    done_base = done_cnt;
    ovr_base  = ovr_cnt;
    px_color0 = {tag, 8'h00};
    vcount    = y;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic wait_acc(input int n);
    int k;
    k = 0;
    while ((acc_cnt - acc_base) < n && k < 1000) begin tick(); k++; end
    if (k >= 1000) chk("wait_acc_timeout", 32'(acc_cnt - acc_base), n);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done_cnt == done_base && k < budget) begin tick(); k++; end
    if (k >= budget) chk("line_done_timeout", 0, 1);
    repeat (3) tick();
  endtask

  task automatic line_totals(input string nm);
    chk({nm, "_accepted"}, acc_cnt - acc_base, 240);
    chk({nm, "_outputs"}, out_cnt - out_base, 240);
    chk({nm, "_line_done"}, done_cnt - done_base, 1);
  endtask

  initial begin
    reset_n = 1'b0; line_start = 1'b0; vcount = '0;
    bldcnt_io = '0; bldalpha_io = '0; bldy_io = '0;
    px_valid = 1'b0; px_layer0 = 20'hABCDE; px_layer1 = 20'h12345;
    px_color0 = '0; px_color1 = 15'h5555; px_effects = 5'h15; out_ready = 1'b0;
`ifdef BLEND_FORCE_BLANK_EN
    force_blank = 1'b0;
`endif
    #2;
    chk("rst_px_ready", 32'(px_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_bldcnt", 32'(blend_bldcnt), 0);
    chk("rst_out_x", 32'(out_x), 0);
    chk("rst_line_done", 32'(line_done), 0);

    @(posedge clock); #1;
    reset_n = 1'b1;
    px_valid = 1'b1; out_ready = 1'b1;
    bldcnt_io = 16'h3F41; bldalpha_io = 16'h0010; bldy_io = 16'h0005;
    mon_en = 1;
    repeat (3) tick();
    chk("idle_px_ready", 32'(px_ready), 0);

    // Line 1: plain streaming, mid-line BLDALPHA write.
    start_line(7'd1, 8'd10);
    chk("l1_bldcnt", 32'(blend_bldcnt), 32'h3F41);
    repeat (50) tick();
    bldalpha_io = 16'h1010;
    tick();
    chk("l1_bldalpha_mid", 32'(blend_bldalpha), 32'h0010);
    chk("l1_layer0", 32'(blend_layer0), 32'hABCDE);
    chk("l1_effects", 32'(blend_effects), 32'h15);
    wait_done(600);
    line_totals("l1");
    chk("l1_latency", first_out_cyc - first_acc_cyc, 2);
    chk("l1_overrun", ovr_cnt - ovr_base, 0);
    chk("l1_bldalpha_end", 32'(blend_bldalpha), 32'h0010);
    chk("l1_idle_ready", 32'(px_ready), 0);

    // Line 2: out_ready toggles 1010...
    start_line(7'd2, 8'd11);
    chk("l2_bldalpha", 32'(blend_bldalpha), 32'h1010);
    toggle = 1;
    wait_done(1500);
    toggle = 0; out_ready = 1'b1;
    line_totals("l2");
    chk("l2_stall_seen", (first_stall >= 0) ? 1 : 0, 1);
    chk("l2_ready_drop", (first_drop >= first_stall && first_drop - first_stall <= 2) ? 1 : 0, 1);

    // Line 3: line_start at pixel 100 is an overrun.
    start_line(7'd3, 8'd12);
    wait_acc(100);
    vcount = 8'd99; bldcnt_io = 16'h1234; line_start = 1'b1;
    tick();
    line_start = 1'b0;
    chk("l3_bldcnt_kept", 32'(blend_bldcnt), 32'h3F41);
    wait_done(600);
    line_totals("l3");
    chk("l3_overrun", ovr_cnt - ovr_base, 1);

    // Line 4: reset mid-line.
    start_line(7'd4, 8'd13);
    wait_acc(50);
    mon_en = 0;
    reset_n = 1'b0;
    #1;
    chk("l4_rst_out_valid", 32'(out_valid), 0);
    chk("l4_rst_px_ready", 32'(px_ready), 0);
    chk("l4_rst_bldcnt", 32'(blend_bldcnt), 0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (4) tick();
    chk("l4_post_px_ready", 32'(px_ready), 0);
    chk("l4_post_out_valid", 32'(out_valid), 0);
    mon_en = 1;

    // Line 5: recovery after reset; force-blank pixel 5 when built in.
`ifdef BLEND_FORCE_BLANK_EN
    fb_on = 1;
`endif
    start_line(7'd5, 8'd14);
    chk("l5_bldcnt", 32'(blend_bldcnt), 32'h1234);
    wait_done(600);
    line_totals("l5");
    chk("l5_overrun", ovr_cnt - ovr_base, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
